// File: rtl/pipe_stage_skid_reg.sv
// Elastic valid/ready pipeline stage with a two-entry skid buffer.
// Optional perf counters are enabled with the PIPE_STAGE_PERF_EN macro.
module pipe_stage_skid_reg #(
    parameter int PAYLOAD_W      = 66,
    parameter int CLEAR_ON_FLUSH = 1,
    parameter int CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [1:0]           occupancy,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    // Encoding equals the beat count, so the handshake outputs
    // come straight off the state flops.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               state;
    logic [PAYLOAD_W-1:0] main_q;
    logic [PAYLOAD_W-1:0] skid_q;
    logic                 in_fire;
    logic                 out_fire;

    assign occupancy = state;
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Beat bookkeeping: main feeds the output, skid catches overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state <= EMPTY;
            if (CLEAR_ON_FLUSH != 0) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q <= in_data;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && !out_fire) begin
                        skid_q <= in_data;
                        state  <= FULL;
                    end else if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_q <= skid_q;
                        state  <= BUSY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

    // Saturating stall/bubble counters; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else if (cnt_clr) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_q != '1))
                stall_q <= stall_q + CNT_ONE;
            if (!out_valid && out_ready && (bubble_q != '1))
                bubble_q <= bubble_q + CNT_ONE;
        end
    end
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign stall_cnt      = '0;
    assign bubble_cnt     = '0;
`endif

endmodule
